seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised sequential shift-add multiplier for the ALU datapath, supporting unsigned (MULTU) and signed (MULT) operation selected by the function code on `Signal`. It accepts operands on a start handshake and iterates one multiplier bit per clock. It then presents a registered double-width product with a one-cycle done pulse. The product feeds the HI/LO register pair.

## Interface
- `WIDTH`, default 32: operand width in bits; product is 2*WIDTH.
- `FUNCT_MULT`, default 6'b011000: function code for signed multiply.
- `FUNCT_MULTU`, default 6'b011001: function code for unsigned multiply.

- `clk`  in  1: clock; all state changes on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only when `busy`=0.
- `Signal`  in  6: function code; sampled with `start`.
- `dataA`  in  WIDTH: multiplicand; sampled with `start`.
- `dataB`  in  WIDTH: multiplier; sampled with `start`.
- `busy`  out  1: iteration in progress.
- `done`  out  1: one-cycle pulse; `dataOut` holds a new valid result.
- `dataOut`  out  2*WIDTH: product; {HI, LO} = {dataOut[2W-1:W], dataOut[W-1:0]}.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Accept:
  - A request is accepted when `busy`=0, `start`=1 and `Signal` is FUNCT_MULT or FUNCT_MULTU.
  - A `start` with any other `Signal` is ignored. State and `dataOut` are unchanged.
- On accept:
  - Latch the mode.
  - Latch the operand magnitudes: |dataA| and |dataB| in signed mode, the raw operands in unsigned mode.
  - Latch neg = dataA[W-1]^dataB[W-1] in signed mode, 0 in unsigned mode.
  - Clear the internal accumulator and the counter, then go to RUN.
- RUN, per cycle:
  - If multiplier LSB = 1, add the 2W-bit zero-extended multiplicand (shifted) into the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1, then increment the counter.
  - After WIDTH iterations, write the accumulator to `dataOut` (two's-complement negated if neg), go to DONE.
- DONE: `done`=1 for this cycle only, then go to IDLE. `start` is accepted in DONE, which gives a back-to-back start.
- Accepted operands are private copies. Input changes while `busy`=1 do not affect the result.
- `start` while `busy`=1 is ignored; it is neither queued nor an error.
- Arithmetic:
  - Accumulator is 2W bits. Unsigned sums cannot overflow.
  - Signed most-negative operands: magnitude 2^(W-1) is taken as an unsigned W-bit value. The product is exact, e.g. (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).
- `dataOut` holds its last value until the next completion or reset. It is never updated mid-iteration.

## Timing
- Reset values: `busy`=0, `done`=0, `dataOut`=0. State IDLE, counter 0, accumulator 0.
- Request accepted at edge E0. `busy`=1 from after E0 through edge E_WIDTH.
- After edge E_WIDTH: `busy`=0, `done`=1, `dataOut` holds the new product.
- After E_WIDTH+1: `done`=0. Latency from start to done is WIDTH edges. Throughput is one product per WIDTH+1 cycles.
- Back-to-back: `start`=1 during the DONE cycle is accepted at E_WIDTH+1. The next `done` follows WIDTH edges later.
- Reset mid-operation takes effect at the next edge and overrides everything else:
  - State returns to IDLE, `dataOut`=0, `done`=0.
  - The aborted result is never presented.
- `reset` and `start` high in the same cycle: reset wins and the request is dropped.

## Test plan
- Unsigned, WIDTH=32, `Signal`=FUNCT_MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> `done` after exactly 32 edges, `dataOut`=0xFFFFFFFE00000001.
- Signed, A=-3 (0xFFFFFFFD), B=7 -> `dataOut`=0xFFFFFFFFFFFFFFEB (-21). Also A=0x80000000, B=0x80000000 signed -> 0x4000000000000000.
- Operand stability: start with A=6, B=7 unsigned, then change `dataA`/`dataB` and pulse `start` during RUN -> single `done`, `dataOut`=42, no second start.
- Back-to-back: start A=5, B=9, then assert start during DONE with A=0, B=123 -> `dataOut`=45 with `done`, then `dataOut`=0 with `done` 33 edges after the first `done`.
- Reset mid-run: reset asserted at iteration 10 -> next cycle `busy`=0, `done`=0, `dataOut`=0. No `done` appears afterwards without a new start.
- Illegal code and parameter: `start` with `Signal`=6'b100000 -> `busy` stays 0, `dataOut` unchanged. With WIDTH=8, unsigned 0xFF*0xFF -> 0xFE01 after 8 edges.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier (signed MULT / unsigned MULTU), one bit per clock.
// Ports: clk, reset (sync, active-high), start/Signal/dataA/dataB in; busy, done, dataOut {HI,LO} out.
module seq_multiplier #(
  parameter int          WIDTH       = 32,
  parameter logic [5:0]  FUNCT_MULT  = 6'b011000,
  parameter logic [5:0]  FUNCT_MULTU = 6'b011001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [5:0]           Signal,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   dataOut
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               mode_s;
  logic               neg;

  logic               sig_s;
  logic               legal;
  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_nxt;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    sig_s   = (Signal == FUNCT_MULT);
    legal   = sig_s || (Signal == FUNCT_MULTU);
    accept  = !busy && start && legal;
    // -MIN wraps to MIN, which read as unsigned is the exact magnitude.
    a_mag   = (sig_s && dataA[WIDTH-1]) ? -dataA : dataA;
    b_mag   = (sig_s && dataB[WIDTH-1]) ? -dataB : dataB;
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    last    = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      mode_s  <= 1'b0;
      neg     <= 1'b0;
      dataOut <= '0;
    end else begin
      case (state)
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (last) begin
            dataOut <= (mode_s && neg) ? -acc_nxt : acc_nxt;
            state   <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept, so DONE allows back-to-back issue.
          if (accept) begin
            mode_s <= sig_s;
            neg    <= sig_s && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: random and directed products vs arithmetic model.
// Checks result, latency, busy/done behaviour, reset abort and an 8-bit instance.
module tb_seq_multiplier;

  localparam logic [5:0] FM  = 6'b011000;
  localparam logic [5:0] FMU = 6'b011001;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic        done;
  logic [63:0] dataOut;

  logic        start8;
  logic [5:0]  sig8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] out8;

  always #5 clk = ~clk;

  seq_multiplier dut (
    .clk(clk), .reset(reset), .start(start), .Signal(Signal),
    .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
    .dataOut(dataOut)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .Signal(sig8),
    .dataA(a8), .dataB(b8), .busy(busy8), .done(done8),
    .dataOut(out8)
  );

  typedef struct {
    logic [63:0] p;
    int          c;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done got=%h want=no_done", dataOut);
      end else begin
        e = q.pop_front();
        if (dataOut !== e.p || cyc != e.c) begin
          bad++;
          $display("FAIL product got=%h@%0d want=%h@%0d",
                   dataOut, cyc, e.p, e.c);
        end
      end
    end
  end

  function automatic logic [63:0] ref_mul(logic [31:0] a,
                                          logic [31:0] b, bit s);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 5)
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL idle_timeout got=busy want=idle");
    end
  endtask

  task automatic issue(logic [31:0] a, logic [31:0] b, bit s,
                       logic [63:0] want, bit garbage);
    wait_idle();
    dataA  = a;
    dataB  = b;
    Signal = s ? FM : FMU;
    start  = 1'b1;
    step();
    q.push_back('{p: want, c: cyc + 32});
    start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    if (garbage) begin
      repeat (20) begin
        dataA  = $urandom;
        dataB  = $urandom;
        Signal = ($urandom % 2) ? FM : FMU;
        start  = 1'($urandom % 2);
        step();
      end
      start = 1'b0;
    end
  endtask

  task automatic run8(logic [7:0] a, logic [7:0] b, bit s,
                      logic [15:0] want);
    int n = 0;
    a8     = a;
    b8     = b;
    sig8   = s ? FM : FMU;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    while (done8 !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("w8_latency", 64'(n), 64'd8);
    chk("w8_product", 64'(out8), 64'(want));
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    Signal = FMU;
    dataA  = '0;
    dataB  = '0;
    start8 = 1'b0;
    sig8   = FMU;
    a8     = '0;
    b8     = '0;
    step();
    step();
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_out", dataOut, 64'd0);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001, 0);
    issue(32'hFFFF_FFFD, 32'd7, 1, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    issue(32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000, 0);
    issue(32'd6, 32'd7, 0, 64'd42, 1);
    issue(32'd5, 32'd9, 0, 64'd45, 0);
    issue(32'd0, 32'd123, 0, 64'd0, 0);
    wait_idle();
    repeat (3) step();

    dataA  = 32'h1234;
    dataB  = 32'h5678;
    Signal = 6'b100000;
    start  = 1'b1;
    step();
    start = 1'b0;
    chk("illegal_busy", 64'(busy), 64'd0);
    repeat (3) step();
    chk("illegal_busy_later", 64'(busy), 64'd0);
    chk("illegal_out", dataOut, 64'd0);

    issue(32'd3, 32'd3, 0, 64'd9, 0);
    wait_idle();
    step();
    chk("hold_out", dataOut, 64'd9);

    dataA  = 32'd100;
    dataB  = 32'd200;
    Signal = FMU;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_out", dataOut, 64'd0);
    repeat (40) step();

    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("reset_vs_start", 64'(busy), 64'd0);
    repeat (40) step();

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      bit          s;
      a = pick();
      b = pick();
      s = 1'($urandom % 2);
      issue(a, b, s, ref_mul(a, b, s), 1'($urandom % 2));
      if ($urandom % 2) begin
        wait_idle();
        repeat ($urandom % 3) step();
      end
    end
    wait_idle();
    repeat (3) step();
    chk("queue_drained", 64'(q.size()), 64'd0);

    run8(8'hFF, 8'hFF, 0, 16'hFE01);
    run8(8'h80, 8'h80, 1, 16'h4000);
    run8(8'hFD, 8'h07, 1, 16'hFFEB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
